// File: rtl/vga_pkg.sv
// Timing defaults and shared types for the VGA sync generator (640x480@60 geometry).
package vga_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Asserted level of hsync/vsync: 0 = active-low, 1 = active-high.
    localparam logic DEF_SYNC_POL = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bus between the sync generator (master) and its consumers (slave).
// VGA_RGB_BLANK_EN adds the RGB pass-through/blanking signals.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic pix_en;
    cnt_t h_counter;
    cnt_t v_counter;
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;

`ifdef VGA_RGB_BLANK_EN
    logic [3:0] red_in;
    logic [3:0] green_in;
    logic [3:0] blue_in;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    modport master (
        input  pix_en, red_in, green_in, blue_in,
        output h_counter, v_counter, hsync, vsync, video_on, line_start, frame_start,
        output red, green, blue
    );
    modport slave (
        output pix_en, red_in, green_in, blue_in,
        input  h_counter, v_counter, hsync, vsync, video_on, line_start, frame_start,
        input  red, green, blue
    );
`else
    modport master (
        input  pix_en,
        output h_counter, v_counter, hsync, vsync, video_on, line_start, frame_start
    );
    modport slave (
        output pix_en,
        input  h_counter, v_counter, hsync, vsync, video_on, line_start, frame_start
    );
`endif

endinterface

// File: rtl/vga_axis_cnt.sv
// Wrapping 0..TOTAL-1 position counter for one axis, with active/sync window decode of the next value.
// Latency: count registered; wrap/active_nxt/sync_nxt are combinational lookahead. No backpressure; en only.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output cnt_t cnt,
    output logic wrap,
    output logic active_nxt,
    output logic sync_nxt
);

    cnt_t cnt_nxt;

    // Decode from the next value so registered flags line up with the counter.
    always_comb begin
        wrap    = en && (cnt == cnt_t'(TOTAL - 1));
        cnt_nxt = cnt;
        if (wrap)
            cnt_nxt = '0;
        else if (en)
            cnt_nxt = cnt + 1'b1;
        active_nxt = (cnt_nxt < cnt_t'(ACTIVE));
        sync_nxt   = (cnt_nxt >= cnt_t'(SYNC_START)) &&
                     (cnt_nxt <  cnt_t'(SYNC_START + SYNC_LEN));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= cnt_t'(TOTAL - 1);
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v position, hsync/vsync, video_on, line/frame strobes; VGA_RGB_BLANK_EN adds RGB blanking.
// Latency: all outputs registered, updated 1 clk after a pix_en edge (RGB and syncs 1 pixel later with RGB).
// Backpressure: none; advances exactly one pixel per pix_en, holds otherwise.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    cnt_t h_cnt, v_cnt;
    logic h_wrap, v_wrap;
    logic h_act_nxt, v_act_nxt;
    logic h_sync_nxt, v_sync_nxt;
    logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    vga_axis_cnt #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
    ) u_h_cnt (
        .clk(clk), .rst_n(rst_n), .en(vga.pix_en), .cnt(h_cnt),
        .wrap(h_wrap), .active_nxt(h_act_nxt), .sync_nxt(h_sync_nxt)
    );

    // Vertical axis steps only on the horizontal wrap.
    vga_axis_cnt #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
    ) u_v_cnt (
        .clk(clk), .rst_n(rst_n), .en(h_wrap), .cnt(v_cnt),
        .wrap(v_wrap), .active_nxt(v_act_nxt), .sync_nxt(v_sync_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            if (vga.pix_en) begin
                hsync_q    <= sync_level(h_sync_nxt, SYNC_POL);
                vsync_q    <= sync_level(v_sync_nxt, SYNC_POL);
                video_on_q <= h_act_nxt && v_act_nxt;
            end
        end
    end

    assign vga.h_counter   = h_cnt;
    assign vga.v_counter   = v_cnt;
    assign vga.video_on    = video_on_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_RGB_BLANK_EN
    logic       hsync_d, vsync_d;
    logic [3:0] red_q, green_q, blue_q;

    // RGB is captured one pixel late; syncs get the same extra pixel to stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_d <= ~SYNC_POL;
            vsync_d <= ~SYNC_POL;
            red_q   <= 4'h0;
            green_q <= 4'h0;
            blue_q  <= 4'h0;
        end else if (vga.pix_en) begin
            hsync_d <= hsync_q;
            vsync_d <= vsync_q;
            red_q   <= video_on_q ? vga.red_in   : 4'h0;
            green_q <= video_on_q ? vga.green_in : 4'h0;
            blue_q  <= video_on_q ? vga.blue_in  : 4'h0;
        end
    end

    assign vga.hsync = hsync_d;
    assign vga.vsync = vsync_d;
    assign vga.red   = red_q;
    assign vga.green = green_q;
    assign vga.blue  = blue_q;
`else
    assign vga.hsync = hsync_q;
    assign vga.vsync = vsync_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing plus a tiny-raster instance (active-high syncs) for whole-frame coverage.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit pol;
    } tim_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen_if if_d ();
    vga_sync_gen_if if_s ();

    vga_sync_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .vga(if_d)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .vga(if_s)
    );

    obs_t a_d, a_s;
    assign a_d = {if_d.h_counter, if_d.v_counter, if_d.hsync, if_d.vsync,
                  if_d.video_on, if_d.line_start, if_d.frame_start};
    assign a_s = {if_s.h_counter, if_s.v_counter, if_s.hsync, if_s.vsync,
                  if_s.video_on, if_s.line_start, if_s.frame_start};

    tim_t td, ts;
    int   pos_d = 0, pos_s = 0;
    obs_t st_d = '0, st_s = '0;
    obs_t q_d[$];
    obs_t q_s[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference: the raster is a linear pixel index; h/v and every flag follow from it arithmetically.
    task automatic model_step(input tim_t t, input bit r, input bit e,
                              input int pos_i, input obs_t st_i,
                              output int pos_o, output obs_t st_o);
        int ht, vt, h, v;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        pos_o = pos_i;
        st_o  = st_i;
        st_o.ls = 1'b0;
        st_o.fs = 1'b0;
        if (!r) begin
            pos_o    = ht * vt - 1;
            st_o.h   = 16'(ht - 1);
            st_o.v   = 16'(vt - 1);
            st_o.hs  = ~t.pol;
            st_o.vs  = ~t.pol;
            st_o.vid = 1'b0;
        end else if (e) begin
            pos_o    = (pos_i + 1) % (ht * vt);
            h        = pos_o % ht;
            v        = pos_o / ht;
            st_o.h   = 16'(h);
            st_o.v   = 16'(v);
            st_o.hs  = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.pol : ~t.pol;
            st_o.vs  = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.pol : ~t.pol;
            st_o.vid = (h < t.ha) && (v < t.va);
            st_o.ls  = (h == 0);
            st_o.fs  = (pos_o == 0);
        end
    endtask

    task automatic drive(input bit r, input bit e);
        @(negedge clk);
        rst_n       = r;
        if_d.pix_en = e;
        if_s.pix_en = e;
        model_step(td, r, e, pos_d, st_d, pos_d, st_d);
        model_step(ts, r, e, pos_s, st_s, pos_s, st_s);
        q_d.push_back(st_d);
        q_s.push_back(st_s);
    endtask

    task automatic compare(input string nm, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b vid=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b vid=%b ls=%b fs=%b",
                         nm, $time, act.h, act.v, act.hs, act.vs, act.vid, act.ls, act.fs,
                         exp.h, exp.v, exp.hs, exp.vs, exp.vid, exp.ls, exp.fs);
        end
    endtask

    // Monitor: every clk the DUT presents a fresh output sample; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q_d.size() > 0) compare("dflt", a_d, q_d.pop_front());
            if (q_s.size() > 0) compare("small", a_s, q_s.pop_front());
        end
    end

    initial begin
        td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        ts = '{8, 2, 3, 2, 6, 2, 2, 3, 1'b1};
        if_d.pix_en = 1'b0;
        if_s.pix_en = 1'b0;
`ifdef VGA_RGB_BLANK_EN
        if_d.red_in = 4'hf; if_d.green_in = 4'h0; if_d.blue_in = 4'h0;
        if_s.red_in = 4'hf; if_s.green_in = 4'h0; if_s.blue_in = 4'h0;
`endif
        repeat (3) drive(1'b0, 1'b0);

        drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0);

        repeat (100) begin
            drive(1'b1, 1'b1);
            repeat (3) drive(1'b1, 1'b0);
        end

        repeat (3000) drive(1'b1, 1'b1);

        for (int i = 0; i < 1000 && st_d.h != 16'd300; i++) drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);

        repeat (40000) drive($urandom_range(0, 4999) != 0, $urandom_range(0, 3) != 0);

        repeat (2) @(posedge clk);
        #3;
        if (q_d.size() != 0 || q_s.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_d.size(), q_s.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
